// File: rtl/load_align.sv
// Selects the addressed byte/halfword/word of a load and sign- or zero-extends it.
module load_align (
  input  logic [31:0] load_word,
  input  logic [1:0]  addr_low2,
  input  logic        size_1b,
  input  logic        size_2b,
  input  logic        size_4b,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = load_word[7:0];
    case (addr_low2)
      2'd0:    byte_s = load_word[7:0];
      2'd1:    byte_s = load_word[15:8];
      2'd2:    byte_s = load_word[23:16];
      2'd3:    byte_s = load_word[31:24];
      default: byte_s = load_word[7:0];
    endcase
    half_s = addr_low2[1] ? load_word[31:16] : load_word[15:0];

    result = load_word;
    if (size_1b) begin
      result = {{24{is_signed & byte_s[7]}}, byte_s};
    end else if (size_2b) begin
      result = {{16{is_signed & half_s[15]}}, half_s};
    end else if (size_4b) begin
      result = load_word;
    end else begin
      result = load_word;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute payload, aligns load data
// (buffering it across writeback stalls) and drives writeback/forwarding.
module mem_stage (
  input  logic           clk,
  input  logic           reset,
  input  logic           csr_reset,
  input  logic           EX_to_MEM_valid,
  input  logic [156:0]   to_MEM_data,
  output logic           MEM_allow_in,
  input  logic           WB_allow_in,
  output logic           MEM_to_WB_valid,
  output logic [184:0]   to_WB_data,
  input  logic [31:0]    data_sram_rdata,
  output logic           mem_ex,
  output logic [37:0]    MEM_forward
);

  typedef struct packed {
    logic [31:0]                 pc;
    logic [31:0]                 alu_result;
    logic                        rd_1b;
    logic                        rd_2b;
    logic                        rd_4b;
    logic                        rd_signed;
    logic [4:0]                  dest;
    logic                        gr_we;
    logic                        ex_sys;
    logic                        ex_adef;
    logic                        ex_adem;
    logic                        is_ertn;
    logic                        op_csr;
    logic [13:0]                 csr_num;
    logic [31:0]                 csr_wmask;
    logic [31:0]                 rj;
  } mem_payload_t;

  mem_payload_t payload_q, payload_d;
  logic         mem_valid_q, mem_valid_d;
  logic         first_cycle_q, first_cycle_d;
  logic         rdata_buf_valid_q, rdata_buf_valid_d;
  logic [31:0]  rdata_buf_q, rdata_buf_d;

  logic         accept_s;
  logic         leave_s;
  logic         is_load_s;
  logic         capture_s;
  logic [31:0]  load_word_s;
  logic [31:0]  aligned_s;
  logic [31:0]  final_result_s;
  logic [4:0]   mem_dest_s;

  assign MEM_allow_in    = ~mem_valid_q | WB_allow_in;
  assign MEM_to_WB_valid = mem_valid_q;
  assign accept_s        = EX_to_MEM_valid & MEM_allow_in;
  assign leave_s         = mem_valid_q & WB_allow_in;
  assign is_load_s       = payload_q.rd_1b | payload_q.rd_2b | payload_q.rd_4b;
  // SRAM data is only ours in the first cycle; keep it if writeback is not taking it.
  assign capture_s       = mem_valid_q & first_cycle_q & is_load_s & ~WB_allow_in;
  assign load_word_s     = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;

  load_align u_load_align (
    .load_word (load_word_s),
    .addr_low2 (payload_q.alu_result[1:0]),
    .size_1b   (payload_q.rd_1b),
    .size_2b   (payload_q.rd_2b),
    .size_4b   (payload_q.rd_4b),
    .is_signed (payload_q.rd_signed),
    .result    (aligned_s)
  );

  assign final_result_s = is_load_s ? aligned_s : payload_q.alu_result;
  assign mem_dest_s     = payload_q.dest & {5{mem_valid_q & payload_q.gr_we}};

  assign mem_ex = mem_valid_q & (payload_q.ex_sys | payload_q.ex_adef |
                                 payload_q.ex_adem | payload_q.is_ertn);

  assign MEM_forward = {mem_dest_s, final_result_s, payload_q.op_csr & mem_valid_q};

  assign to_WB_data = {payload_q.pc, final_result_s, payload_q.dest, payload_q.gr_we,
                       payload_q.ex_sys, payload_q.ex_adef, payload_q.ex_adem,
                       payload_q.is_ertn, payload_q.op_csr, payload_q.csr_num,
                       payload_q.csr_wmask, payload_q.rj, payload_q.alu_result};

  always_comb begin
    mem_valid_d       = mem_valid_q;
    first_cycle_d     = 1'b0;
    rdata_buf_valid_d = rdata_buf_valid_q;
    rdata_buf_d       = rdata_buf_q;
    payload_d         = accept_s ? mem_payload_t'(to_MEM_data) : payload_q;
    if (csr_reset) begin
      mem_valid_d       = 1'b0;
      first_cycle_d     = 1'b0;
      rdata_buf_valid_d = 1'b0;
    end else begin
      if (MEM_allow_in) begin
        mem_valid_d = EX_to_MEM_valid;
      end else begin
        mem_valid_d = mem_valid_q;
      end
      first_cycle_d = accept_s;
      if (leave_s) begin
        rdata_buf_valid_d = 1'b0;
      end else if (capture_s) begin
        rdata_buf_valid_d = 1'b1;
        rdata_buf_d       = data_sram_rdata;
      end else begin
        rdata_buf_valid_d = rdata_buf_valid_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid_q       <= 1'b0;
      first_cycle_q     <= 1'b0;
      rdata_buf_valid_q <= 1'b0;
      rdata_buf_q       <= 32'h0000_0000;
      payload_q         <= '0;
    end else begin
      mem_valid_q       <= mem_valid_d;
      first_cycle_q     <= first_cycle_d;
      rdata_buf_valid_q <= rdata_buf_valid_d;
      rdata_buf_q       <= rdata_buf_d;
      payload_q         <= payload_d;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage and upstream of writeback.
- Latches the execute-stage payload and captures the synchronous data-SRAM read response.
- Aligns and extends load data, and produces the writeback payload, the forwarding bundle and the exception-pending flag.
- Holds captured load data in a one-entry buffer while writeback stalls.

Parameters:
- none; all field widths come from the shared constants header.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- csr_reset  in  1  synchronous pipeline flush (exception/ertn taken)
- EX_to_MEM_valid  in  1  upstream payload valid
- to_MEM_data  in  `to_MEM_data_width  {pc, alu_result, rd_1B, rd_2B, rd_4B, rd_signed, dest, gr_we, ex_SYS, ex_ADEF, ex_ADEM, is_ertn, op_csr, csr_num, csr_wmask, rj}
- MEM_allow_in  out  1  stage can accept
- WB_allow_in  in  1  downstream can accept
- MEM_to_WB_valid  out  1  payload valid to writeback
- to_WB_data  out  `to_WB_data_width  {pc, final_result, dest, gr_we, ex_SYS, ex_ADEF, ex_ADEM, is_ertn, op_csr, csr_num, csr_wmask, rj, bad_addr=alu_result}
- data_sram_rdata  in  32  SRAM read data; valid only in the cycle after the request
- mem_ex  out  1  stage holds a valid exception/ertn instruction
- MEM_forward  out  `forwrd_data_width+1  {MEM_dest[4:0], final_result[31:0], MEM_op_csr}

Behaviour:
- Only clk and reset are in the asynchronous sensitivity list. reset clears MEM_valid, rdata_buf_valid and first_cycle. csr_reset has the same effect, applied synchronously.
- Outputs while in reset: MEM_to_WB_valid=0, mem_ex=0, MEM_forward dest field=0. MEM_allow_in=1.
- Stage ready_go is always 1. MEM_allow_in = ~MEM_valid | WB_allow_in. MEM_to_WB_valid = MEM_valid.
- Each clock when MEM_allow_in=1: MEM_valid <= EX_to_MEM_valid. The payload register loads only when EX_to_MEM_valid & MEM_allow_in.
- first_cycle is set to 1 on accept and cleared on the next clock. It marks the single cycle in which data_sram_rdata belongs to this instruction.
- Load buffer capture: when MEM_valid & first_cycle & is_load & ~WB_allow_in, rdata_buf <= data_sram_rdata and rdata_buf_valid <= 1.
- Load buffer release: rdata_buf_valid clears when the instruction leaves (MEM_valid & WB_allow_in) or on flush.
- load_word = rdata_buf_valid ? rdata_buf : data_sram_rdata.
- Alignment uses a = alu_result[1:0]. Byte lane = load_word[8a+7 : 8a]. Halfword = a[1] ? load_word[31:16] : load_word[15:0]. Word = load_word.
- Extension: rd_signed sign-extends to 32 bits, otherwise zero-extends.
- is_load = rd_1B|rd_2B|rd_4B. final_result = is_load ? aligned load : alu_result.
- Excepting loads (ex_ADEM/ex_ADEF set): final_result is don't-care. WB must ignore it.
- mem_ex = MEM_valid & (ex_SYS|ex_ADEF|ex_ADEM|is_ertn). It is combinational and feeds the execute stage's SRAM-enable suppression.
- MEM_dest = dest & {5{MEM_valid & gr_we}}. MEM_op_csr = op_csr & MEM_valid.
- Simultaneous accept and leave: new payload loads, first_cycle=1, rdata_buf_valid cleared in the same edge.
- Flush while stalled: buffer discarded; a new accept on the following cycle starts clean.

Decomposition:
- constants.h holds the following; no new package.
  - `to_MEM_data_width
  - `to_WB_data_width
  - `forwrd_data_width
  - `CSR_NUM_WIDTH
- One combinational sub-module, load_align: inputs load_word, addr_low2, size flags, signed; output 32-bit result.

Test Plan:
- ld.b, alu_result=0x1003, next-cycle rdata=0x80123456, WB_allow_in=1 -> final_result=0xFFFFFF80, MEM_to_WB_valid=1 for 1 cycle.
- ld.hu, alu_result low2=2'b10, rdata=0x8001ABCD -> final_result=0x00008001; ld.h same -> 0xFFFF8001.
- ld.w with WB_allow_in=0 for 3 cycles:
  - stimulus: rdata=0xDEADBEEF in the first cycle, then 0x00000000.
  - required: final_result stays 0xDEADBEEF throughout and is delivered when WB_allow_in=1.
  - required: MEM_allow_in=0 while stalled.
- Payload with ex_ADEM=1 -> mem_ex=1 the cycle it is valid. csr_reset next edge -> MEM_valid=0, mem_ex=0, MEM_forward dest=0.
- add.w, dest=5, alu_result=0x12345678 -> MEM_forward={5'd5, 0x12345678, 0}. With op_csr=1 -> LSB=1.
- reset asserted mid-stall between clock edges -> MEM_valid, rdata_buf_valid and MEM_to_WB_valid drop immediately without a clock edge, and MEM_allow_in=1.
